// File: rtl/reg_scan_if.sv
// Snapshot request / serial panel link bundle for reg_scan_reader.
interface reg_scan_if #(
   parameter int WIDTH = 12
);
   logic [WIDTH-1:0] par_in;
   logic             req;
   logic             ack;
   logic             busy;
   logic             sclk;
   logic             sdata;
   logic             sframe;

   modport master (
      output par_in, req,
      input  ack, busy, sclk, sdata, sframe
   );

   modport slave (
      input  par_in, req,
      output ack, busy, sclk, sdata, sframe
   );
endinterface

// File: rtl/reg_scan_reader.sv
// Snapshots a register word and shifts it MSB-first onto the panel link.
// Define REG_SCAN_PARITY_EN to append an even-parity bit after the LSB.
module reg_scan_reader #(
   parameter int WIDTH   = 12,
   parameter int CLK_DIV = 4
) (
   input logic        clk,
   input logic        rst_n,
   reg_scan_if.slave  bus
);

`ifdef REG_SCAN_PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W = $clog2(NBITS + 1);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE
   } state_t;

   state_t           state_q, state_d;
   logic [NBITS-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             ack_q, ack_d;
   logic             busy_q, busy_d;
   logic             sclk_q, sclk_d;
   logic             sdata_q, sdata_d;
   logic             sframe_q, sframe_d;

   logic [NBITS-1:0] capture;
   logic [NBITS-1:0] shifted;

`ifdef REG_SCAN_PARITY_EN
   assign capture = {bus.par_in, ^bus.par_in};
`else
   assign capture = bus.par_in;
`endif
   assign shifted = shreg_q << 1;

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      div_d    = div_q;
      ack_d    = ack_q;
      busy_d   = busy_q;
      sclk_d   = sclk_q;
      sdata_d  = sdata_q;
      sframe_d = sframe_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req && !ack_q) begin
               shreg_d  = capture;
               bitcnt_d = CNT_W'(NBITS);
               busy_d   = 1'b1;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            sframe_d = 1'b1;
            sdata_d  = shreg_q[NBITS-1];
            div_d    = '0;
            state_d  = SHIFT_LO;
         end
         SHIFT_LO: begin
            if (div_q == DIV_MAX) begin
               div_d   = '0;
               sclk_d  = 1'b1;
               state_d = SHIFT_HI;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         SHIFT_HI: begin
            if (div_q == DIV_MAX) begin
               div_d    = '0;
               sclk_d   = 1'b0;
               bitcnt_d = bitcnt_q - CNT_W'(1);
               // bitcnt_q==1 means the bit just clocked was the last one
               if (bitcnt_q != CNT_W'(1)) begin
                  shreg_d = shifted;
                  sdata_d = shifted[NBITS-1];
                  state_d = SHIFT_LO;
               end else begin
                  state_d = DONE;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         DONE: begin
            if (!ack_q) begin
               ack_d    = 1'b1;
               busy_d   = 1'b0;
               sdata_d  = 1'b0;
               sframe_d = 1'b0;
            end else if (!bus.req) begin
               ack_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         div_q    <= '0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         sclk_q   <= 1'b0;
         sdata_q  <= 1'b0;
         sframe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         div_q    <= div_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         sclk_q   <= sclk_d;
         sdata_q  <= sdata_d;
         sframe_q <= sframe_d;
      end
   end

   assign bus.ack    = ack_q;
   assign bus.busy   = busy_q;
   assign bus.sclk   = sclk_q;
   assign bus.sdata  = sdata_q;
   assign bus.sframe = sframe_q;

endmodule

// File: tb/tb_reg_scan_reader.sv
// Directed bench for reg_scan_reader (WIDTH=12, CLK_DIV=4).
// Frame length and ack latency follow REG_SCAN_PARITY_EN when defined.
module tb_reg_scan_reader;

`ifdef REG_SCAN_PARITY_EN
   localparam int NB = 13;
`else
   localparam int NB = 12;
`endif
   localparam int RISE1 = 6;
   localparam int ACKC  = 2 + 2 * 4 * NB + 1;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   reg_scan_if #(.WIDTH(12)) bus ();

   reg_scan_reader #(.WIDTH(12), .CLK_DIV(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] frame_of(input logic [11:0] w);
`ifdef REG_SCAN_PARITY_EN
      return {19'd0, w, ^w};
`else
      return {20'd0, w};
`endif
   endfunction

   // Raises req and records every bit seen at an sclk rise until ack.
   // Cycle n counts rising edges with the one that samples req as n=1.
   task automatic run_frame(input logic [11:0] word, input bit flip,
                            input bit drop,
                            output logic [31:0] bits, output int nb,
                            output int rise1, output int ackc,
                            output logic sf_ack, output logic busy_ack);
      logic prev;
      bits = '0; nb = 0; rise1 = -1; ackc = -1;
      sf_ack = 1'bx; busy_ack = 1'bx; prev = bus.sclk;
      @(negedge clk);
      bus.par_in = word;
      bus.req    = 1'b1;
      for (int n = 1; n <= 400; n++) begin
         @(posedge clk);
         #1;
         if (n == 1 && flip) bus.par_in = ~word;
         if (n == 10 && drop) bus.req = 1'b0;
         if (bus.sclk && !prev) begin
            if (nb == 0) rise1 = n;
            bits = {bits[30:0], bus.sdata};
            nb++;
         end
         prev = bus.sclk;
         if (bus.ack) begin
            ackc     = n;
            sf_ack   = bus.sframe;
            busy_ack = bus.busy;
            break;
         end
      end
   endtask

   initial begin
      logic [31:0] bits;
      int          nb, r1, ac, rises;
      logic        sf, bz, prev;
      checks = 0;
      errors = 0;
      bus.par_in = '0;
      bus.req    = 1'b0;
      rst_n      = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_outs", {27'd0, bus.ack, bus.busy, bus.sclk, bus.sdata,
            bus.sframe}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("idle_outs", {27'd0, bus.ack, bus.busy, bus.sclk, bus.sdata,
            bus.sframe}, 32'd0);

      // Basic frame with latency and end-of-frame checks
      run_frame(12'hA5C, 1'b0, 1'b0, bits, nb, r1, ac, sf, bz);
      check("a5c_nbits", nb, NB);
      check("a5c_bits", bits, frame_of(12'hA5C));
      check("a5c_rise1", r1, RISE1);
      check("a5c_ackc", ac, ACKC);
      check("a5c_sframe", {31'd0, sf}, 32'd0);
      check("a5c_busy", {31'd0, bz}, 32'd0);

      // req held after ack: ack stays, no new frame
      rises = 0;
      prev  = bus.sclk;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (bus.sclk && !prev) rises++;
         prev = bus.sclk;
      end
      check("hold_ack", {31'd0, bus.ack}, 32'd1);
      check("hold_norises", rises, 0);
      check("hold_sframe", {31'd0, bus.sframe}, 32'd0);
      @(negedge clk);
      bus.req = 1'b0;
      @(posedge clk);
      #1;
      check("ack_drop", {31'd0, bus.ack}, 32'd0);

      // Snapshot: input inverted right after capture must not leak in
      run_frame(12'hFFF, 1'b1, 1'b0, bits, nb, r1, ac, sf, bz);
      check("snap_bits", bits, frame_of(12'hFFF));
      check("snap_nbits", nb, NB);
      @(negedge clk);
      bus.req = 1'b0;
      @(posedge clk);
      #1;
      check("snap_ack_drop", {31'd0, bus.ack}, 32'd0);

      // Retrigger after handshake completes
      run_frame(12'h3C1, 1'b0, 1'b0, bits, nb, r1, ac, sf, bz);
      check("retrig_bits", bits, frame_of(12'h3C1));
      check("retrig_ackc", ac, ACKC);
      @(negedge clk);
      bus.req = 1'b0;
      @(posedge clk);
      #1;

      // req dropped mid-frame: frame completes, ack is a one-cycle pulse
      run_frame(12'h5A3, 1'b0, 1'b1, bits, nb, r1, ac, sf, bz);
      check("drop_bits", bits, frame_of(12'h5A3));
      check("drop_ackc", ac, ACKC);
      @(posedge clk);
      #1;
      check("drop_ack_pulse", {31'd0, bus.ack}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("drop_no_restart", {31'd0, bus.busy}, 32'd0);

      // Mid-frame async reset after the 5th sclk rise
      @(negedge clk);
      bus.par_in = 12'hF0F;
      bus.req    = 1'b1;
      rises = 0;
      prev  = bus.sclk;
      for (int i = 0; i < 200 && rises < 5; i++) begin
         @(posedge clk);
         #1;
         if (bus.sclk && !prev) rises++;
         prev = bus.sclk;
      end
      check("mid_rises", rises, 5);
      check("mid_busy_frame", {30'd0, bus.busy, bus.sframe}, 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_outs", {27'd0, bus.ack, bus.busy, bus.sclk, bus.sdata,
            bus.sframe}, 32'd0);
      bus.req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_idle", {27'd0, bus.ack, bus.busy, bus.sclk, bus.sdata,
            bus.sframe}, 32'd0);
      run_frame(12'hA5C, 1'b0, 1'b0, bits, nb, r1, ac, sf, bz);
      check("post_rst_bits", bits, frame_of(12'hA5C));
      check("post_rst_nbits", nb, NB);
      check("post_rst_ackc", ac, ACKC);
      @(negedge clk);
      bus.req = 1'b0;
      @(posedge clk);
      #1;

      // Words whose parity bit differs (1 for 007, 0 for 003)
      run_frame(12'h007, 1'b0, 1'b0, bits, nb, r1, ac, sf, bz);
      check("w007_bits", bits, frame_of(12'h007));
      check("w007_nbits", nb, NB);
      @(negedge clk);
      bus.req = 1'b0;
      @(posedge clk);
      #1;
      run_frame(12'h003, 1'b0, 1'b0, bits, nb, r1, ac, sf, bz);
      check("w003_bits", bits, frame_of(12'h003));
      check("w003_nbits", nb, NB);
      @(negedge clk);
      bus.req = 1'b0;
      @(posedge clk);
      #1;
      check("final_ack", {31'd0, bus.ack}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
